fetch_buffer: RTL and testbench

Parametrised instruction fetch buffer between the instruction cache and the multi-issue decode/datapath lanes; generalises the fixed two-slot instruction0/instruction1 hand-off. A circular queue accepts up to FETCH_W instructions per cycle from fetch and presents up to ISSUE_W oldest instructions with their PCs to the issue lanes. Consumers retire a variable number of lanes per cycle (0 under freeze). Synchronous flush supports branch redirect.

---
 rtl/fetch_pkg.sv | 30 +++
 rtl/fb_ring_ram.sv | 62 ++++++
 rtl/fetch_buffer.sv | 130 +++++++++++++
 tb/tb_fetch_buffer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and width helpers for the instruction fetch
//               buffer. An entry is the pair {instruction word, PC}.
//               Consecutive instructions in a fetch group are PC_STEP apart.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int PC_STEP  = 4;
  localparam int FB_INS_W = 32;

  typedef struct packed {
    logic [FB_INS_W-1:0] ins;
    logic [FB_INS_W-1:0] pc;
  } fb_entry_t;

  // Ring pointer width; a single-entry ring still needs one pointer bit.
  function automatic int fb_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width of a counter that must hold the values 0..n inclusive.
  function automatic int fb_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_ring_ram.sv
`default_nettype none
// ============================================================================
// Module      : fb_ring_ram
// Description : DEPTH-entry storage for the fetch buffer ring. FETCH_W write
//               ports land at consecutive addresses from i_waddr, and ISSUE_W
//               combinational read ports sit at consecutive addresses from
//               i_raddr. All addresses wrap modulo DEPTH, which is a power of
//               2, so pointer truncation does the wrap. Contents are not
//               reset; occupancy tracking lives in the parent.
// Ports       : clk     - write clock
//               i_we    - per write lane enable
//               i_waddr - address of write lane 0
//               i_wins  - write instruction words, lane 0 in LSBs
//               i_wpc   - write PCs, lane 0 in LSBs
//               i_raddr - address of read lane 0
//               o_rins  - read instruction words, lane 0 in LSBs
//               o_rpc   - read PCs, lane 0 in LSBs
// Revision    : 1.0 - initial release
// ============================================================================
module fb_ring_ram import fetch_pkg::*; #(
  parameter int INS_W   = 32,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 8,
  parameter int PTR_W   = fb_ptr_w(DEPTH)
) (
  input  logic                     clk,
  input  logic [FETCH_W-1:0]       i_we,
  input  logic [PTR_W-1:0]         i_waddr,
  input  logic [FETCH_W*INS_W-1:0] i_wins,
  input  logic [FETCH_W*INS_W-1:0] i_wpc,
  input  logic [PTR_W-1:0]         i_raddr,
  output logic [ISSUE_W*INS_W-1:0] o_rins,
  output logic [ISSUE_W*INS_W-1:0] o_rpc
);

  logic [INS_W-1:0] r_ins [DEPTH];
  logic [INS_W-1:0] r_pc  [DEPTH];
  logic [PTR_W-1:0] w_wa  [FETCH_W];
  logic [PTR_W-1:0] w_ra  [ISSUE_W];

  for (genvar k = 0; k < FETCH_W; k++) begin : g_waddr
    assign w_wa[k] = i_waddr + PTR_W'(k);
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_W; k++) begin
      if (i_we[k]) begin
        r_ins[w_wa[k]] <= i_wins[k*INS_W +: INS_W];
        r_pc[w_wa[k]]  <= i_wpc[k*INS_W +: INS_W];
      end
    end
  end

  for (genvar i = 0; i < ISSUE_W; i++) begin : g_rd
    assign w_ra[i]                    = i_raddr + PTR_W'(i);
    assign o_rins[i*INS_W +: INS_W]   = r_ins[w_ra[i]];
    assign o_rpc[i*INS_W +: INS_W]    = r_pc[w_ra[i]];
  end

endmodule
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : Circular instruction fetch buffer between the I-cache and the
//               issue lanes. Accepts up to FETCH_W instructions per cycle and
//               presents the ISSUE_W oldest with their PCs. Consumers retire
//               a variable number of lanes per cycle; flush clears the queue
//               for branch redirect. Pushed entries appear on the issue view
//               one cycle after they are written (no bypass).
// Ports       : clk, rst   - clock, async active-high reset
//               flush      - synchronous clear, beats push and pop
//               in_valid / in_ready / in_count / in_ins / in_pc - fetch group
//               out_valid / out_ins / out_pc - thermometer issue view
//               out_take   - lanes consumed this cycle (clamped)
//               count / empty / full / hwm - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer import fetch_pkg::*; #(
  parameter int INS_W   = 32,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [fb_cnt_w(FETCH_W)-1:0]   in_count,
  input  logic [FETCH_W*INS_W-1:0]       in_ins,
  input  logic [INS_W-1:0]               in_pc,
  output logic [ISSUE_W-1:0]             out_valid,
  output logic [ISSUE_W*INS_W-1:0]       out_ins,
  output logic [ISSUE_W*INS_W-1:0]       out_pc,
  input  logic [fb_cnt_w(ISSUE_W)-1:0]   out_take,
  output logic [fb_cnt_w(DEPTH)-1:0]     count,
  output logic                           empty,
  output logic                           full,
  output logic [fb_cnt_w(DEPTH)-1:0]     hwm
);

  localparam int PTR_W = fb_ptr_w(DEPTH);
  localparam int CNT_W = fb_cnt_w(DEPTH);
  localparam int IC_W  = fb_cnt_w(FETCH_W);

  logic [PTR_W-1:0]         r_head;
  logic [PTR_W-1:0]         r_tail;
  logic [CNT_W-1:0]         r_count;
  logic [CNT_W-1:0]         r_hwm;

  logic                     w_push;
  logic [CNT_W-1:0]         w_n;
  logic [CNT_W-1:0]         w_avail;
  logic [CNT_W-1:0]         w_t;
  logic [CNT_W-1:0]         w_count_nxt;
  logic [FETCH_W-1:0]       w_we;
  logic [FETCH_W*INS_W-1:0] w_wpc;
  logic [ISSUE_W*INS_W-1:0] w_rins;
  logic [ISSUE_W*INS_W-1:0] w_rpc;

  // Readiness is from registered occupancy only: no credit for a same-cycle pop.
  assign in_ready = (CNT_W'(DEPTH) - r_count) >= CNT_W'(FETCH_W);

  always_comb begin
    w_push      = in_valid && in_ready && !flush;
    w_n         = '0;
    if (w_push) begin
      w_n = (in_count > IC_W'(FETCH_W)) ? CNT_W'(FETCH_W) : CNT_W'(in_count);
    end
    // Pops are limited to lanes actually showing valid data.
    w_avail     = (r_count > CNT_W'(ISSUE_W)) ? CNT_W'(ISSUE_W) : r_count;
    w_t         = (CNT_W'(out_take) > w_avail) ? w_avail : CNT_W'(out_take);
    w_count_nxt = r_count + w_n - w_t;
  end

  for (genvar k = 0; k < FETCH_W; k++) begin : g_wr
    assign w_we[k]                   = (CNT_W'(k) < w_n);
    assign w_wpc[k*INS_W +: INS_W]   = in_pc + INS_W'(PC_STEP * k);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_hwm   <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_hwm   <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_t);
      r_tail  <= r_tail + PTR_W'(w_n);
      r_count <= w_count_nxt;
      r_hwm   <= (w_count_nxt > r_hwm) ? w_count_nxt : r_hwm;
    end
  end

  fb_ring_ram #(
    .INS_W   (INS_W),
    .FETCH_W (FETCH_W),
    .ISSUE_W (ISSUE_W),
    .DEPTH   (DEPTH),
    .PTR_W   (PTR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_tail),
    .i_wins  (in_ins),
    .i_wpc   (w_wpc),
    .i_raddr (r_head),
    .o_rins  (w_rins),
    .o_rpc   (w_rpc)
  );

  // Lanes beyond the occupancy are masked to zero so stale ring data never leaks.
  for (genvar i = 0; i < ISSUE_W; i++) begin : g_lane
    assign out_valid[i]              = (r_count > CNT_W'(i));
    assign out_ins[i*INS_W +: INS_W] = out_valid[i] ? w_rins[i*INS_W +: INS_W] : '0;
    assign out_pc[i*INS_W +: INS_W]  = out_valid[i] ? w_rpc[i*INS_W +: INS_W]  : '0;
  end

  assign count = r_count;
  assign empty = (r_count == '0);
  assign full  = (r_count == CNT_W'(DEPTH));
  assign hwm   = r_hwm;

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_buffer
// Description : Self-checking bench for fetch_buffer. A queue of entries
//               models the buffer; outputs are compared against it every
//               cycle on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_buffer;
  import fetch_pkg::*;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_count;
  logic [63:0] in_ins;
  logic [31:0] in_pc;
  logic [1:0]  out_valid;
  logic [63:0] out_ins;
  logic [63:0] out_pc;
  logic [1:0]  out_take;
  logic [3:0]  count;
  logic        empty;
  logic        full;
  logic [3:0]  hwm;

  int total = 0;
  int bad   = 0;

  fb_entry_t q[$];
  int        m_hwm = 0;
  logic [31:0] npc;

  fetch_buffer #(.INS_W(32), .FETCH_W(2), .ISSUE_W(2), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_count(in_count),
    .in_ins(in_ins), .in_pc(in_pc),
    .out_valid(out_valid), .out_ins(out_ins), .out_pc(out_pc),
    .out_take(out_take), .count(count), .empty(empty), .full(full), .hwm(hwm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [1:0]  ev;
    logic [63:0] ei;
    logic [63:0] ep;
    int          sz;
    sz = q.size();
    ev = '0;
    ei = '0;
    ep = '0;
    for (int i = 0; i < 2; i++) begin
      if (i < sz) begin
        ev[i]          = 1'b1;
        ei[i*32 +: 32] = q[i].ins;
        ep[i*32 +: 32] = q[i].pc;
      end
    end
    chk("count",     64'(count),     64'(sz));
    chk("empty",     64'(empty),     64'(sz == 0));
    chk("full",      64'(full),      64'(sz == DEPTH));
    chk("in_ready",  64'(in_ready),  64'((DEPTH - sz) >= 2));
    chk("hwm",       64'(hwm),       64'(m_hwm));
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("out_ins",   out_ins,        ei);
    chk("out_pc",    out_pc,         ep);
  endtask

  // Check current state, apply one cycle of inputs, advance the model, wait.
  task automatic step(input bit v, input logic [1:0] c, input logic [1:0] tk,
                      input bit fl, input logic [31:0] pc);
    int        sz;
    int        t;
    int        n;
    fb_entry_t e;
    check_all();
    in_valid = v;
    in_count = c;
    out_take = tk;
    flush    = fl;
    in_pc    = pc;
    in_ins   = {$urandom(), $urandom()};
    if (fl) begin
      q.delete();
      m_hwm = 0;
    end else begin
      sz = q.size();
      t  = int'(tk);
      if (t > sz) t = sz;
      if (t > 2)  t = 2;
      n  = (v && (DEPTH - sz) >= 2) ? ((int'(c) > 2) ? 2 : int'(c)) : 0;
      for (int i = 0; i < t; i++) void'(q.pop_front());
      for (int k = 0; k < n; k++) begin
        e.ins = in_ins[k*32 +: 32];
        e.pc  = pc + 32'(PC_STEP * k);
        q.push_back(e);
      end
      if (q.size() > m_hwm) m_hwm = q.size();
    end
    @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 2'd0, 2'd0, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_count = '0;
    in_ins = '0; in_pc = '0; out_take = '0;
    #10;
    rst = 1'b0;
    @(negedge clk);

    // Reset then idle
    idle(5);

    // First group, then frozen
    check_all();
    in_valid = 1'b1; in_count = 2'd2; out_take = 2'd0; flush = 1'b0;
    in_pc = 32'h100; in_ins = {32'h00A00113, 32'h00500093};
    q.push_back('{ins: 32'h00500093, pc: 32'h100});
    q.push_back('{ins: 32'h00A00113, pc: 32'h104});
    m_hwm = 2;
    @(negedge clk);
    chk("first_pc0", 64'(out_pc[31:0]),   64'h100);
    chk("first_pc1", 64'(out_pc[63:32]),  64'h104);
    chk("first_ins0", 64'(out_ins[31:0]), 64'h00500093);
    idle(3);

    // Fill from empty with four pushes of two, then an ignored fifth offer
    step(1'b0, 2'd0, 2'd0, 1'b1, 32'h0);
    npc = 32'h200;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'd2, 2'd0, 1'b0, npc);
      npc += 8;
    end
    step(1'b1, 2'd2, 2'd0, 1'b0, npc);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_hwm",  64'(hwm),  64'd8);

    // Drop to 6, then steady push-2/take-2 across the pointer wrap
    step(1'b0, 2'd0, 2'd2, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'd2, 2'd2, 1'b0, npc);
      npc += 8;
    end
    chk("wrap_count", 64'(count), 64'd6);

    // Over-take and partial group
    step(1'b0, 2'd0, 2'd0, 1'b1, 32'h0);
    step(1'b1, 2'd1, 2'd0, 1'b0, 32'h300);
    step(1'b0, 2'd0, 2'd2, 1'b0, 32'h0);
    step(1'b1, 2'd1, 2'd0, 1'b0, 32'h400);
    chk("partial_valid", 64'(out_valid), 64'b01);

    // Flush dominating a same-cycle push and pop
    step(1'b1, 2'd2, 2'd0, 1'b0, 32'h500);
    step(1'b1, 2'd2, 2'd0, 1'b0, 32'h508);
    step(1'b0, 2'd0, 2'd0, 1'b0, 32'h0);
    chk("pre_flush_count", 64'(count), 64'd5);
    step(1'b1, 2'd2, 2'd1, 1'b1, 32'h600);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_hwm",   64'(hwm),   64'd0);

    // Asynchronous reset in the middle of filling
    step(1'b1, 2'd2, 2'd0, 1'b0, 32'h700);
    step(1'b1, 2'd2, 2'd0, 1'b0, 32'h708);
    check_all();
    in_valid = 1'b0; in_count = '0; out_take = '0;
    #1;
    rst = 1'b1;
    #1;
    q.delete();
    m_hwm = 0;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 2'd2, 2'd0, 1'b0, 32'h800);
    check_all();

    // Randomised traffic
    npc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(3) != 0), 2'($urandom_range(3)), 2'($urandom_range(3)),
           ($urandom_range(31) == 0), npc);
      npc += 8;
    end
    check_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
